alu_cmd_stage: RTL and testbench

//  Command buffer and result stage wrapped around the 4-bit ALU (MyALU). Accepts ALU commands
//  {op, A, B} over a valid/ready handshake and buffers them in a small FIFO. Issues one command
//  per cycle to the combinational ALU and registers the result and flags into an output slot.
//  The output slot has its own valid/ready handshake.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_cmd_stage_if.sv | 46 ++++
 rtl/alu_cmd_fifo.sv | 60 ++++++
 rtl/alu_cmd_stage.sv | 115 +++++++++++
 tb/tb_alu_cmd_stage.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU command stage: op encodings, command entry, result flags, slot state.
// Latency: n/a (types only).
// Backpressure: n/a.
package alu_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'h0,
    OP_SUB = 3'h1,
    OP_NOT = 3'h2,
    OP_AND = 3'h3,
    OP_OR  = 3'h4,
    OP_XOR = 3'h5,
    OP_SLT = 3'h6,
    OP_NOP = 3'h7
  } op_e;

  typedef struct packed {
    op_e              op;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic             fwd;
  } cmd_t;

  typedef struct packed {
    logic ovf;
    logic carry;
    logic zero;
  } flags_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

endpackage

// File: rtl/alu_cmd_stage_if.sv
// Bundle of command-in, ALU-side and result-out signals of the ALU command stage.
// Latency: n/a (wiring only).
// Backpressure: io_in_ready toward the producer, io_out_ready from the consumer.
interface alu_cmd_stage_if #(
  parameter int W     = 4,
  parameter int CNT_W = 8
);
  logic             io_in_valid;
  logic             io_in_ready;
  logic [2:0]       io_in_op;
  logic [W-1:0]     io_in_a;
  logic [W-1:0]     io_in_b;
  logic             io_in_fwd;
  logic [W-1:0]     io_alu_A;
  logic [W-1:0]     io_alu_B;
  logic [2:0]       io_alu_op_type;
  logic [W-1:0]     io_alu_out;
  logic             io_alu_zero;
  logic             io_alu_carry;
  logic             io_alu_overflow;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [W-1:0]     io_out_data;
  logic [2:0]       io_out_flags;
  logic             io_sticky_ovf;
  logic             io_clr_sticky;
  logic [CNT_W-1:0] io_issued_cnt;

  // Environment side: producer, consumer and the external ALU.
  modport master (
    output io_in_valid, io_in_op, io_in_a, io_in_b, io_in_fwd,
    output io_alu_out, io_alu_zero, io_alu_carry, io_alu_overflow,
    output io_out_ready, io_clr_sticky,
    input  io_in_ready, io_alu_A, io_alu_B, io_alu_op_type,
    input  io_out_valid, io_out_data, io_out_flags, io_sticky_ovf, io_issued_cnt
  );

  // Stage side.
  modport slave (
    input  io_in_valid, io_in_op, io_in_a, io_in_b, io_in_fwd,
    input  io_alu_out, io_alu_zero, io_alu_carry, io_alu_overflow,
    input  io_out_ready, io_clr_sticky,
    output io_in_ready, io_alu_A, io_alu_B, io_alu_op_type,
    output io_out_valid, io_out_data, io_out_flags, io_sticky_ovf, io_issued_cnt
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// DEPTH-entry synchronous FIFO of cmd_t; head is visible combinationally while non-empty.
// Latency: a push is visible at the head one edge later.
// Backpressure: push ignored when full (even with a same-cycle pop); pop ignored when empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  cmd_t push_dat,
  input  logic pop,
  output cmd_t head_dat,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  cmd_t          mem_q [DEPTH];
  cmd_t          mem_d [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push;
  logic          do_pop;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state for storage and pointers.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage and pointer registers; reset empties the FIFO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/alu_cmd_stage.sv
// Command FIFO + one-deep registered result slot around an external combinational ALU.
// Latency: push at edge N into an idle stage -> io_out_valid after edge N+1; 1 result/cycle.
// Backpressure: io_in_ready = !full; slot holds its result until io_out_ready. Option: ALU_FWD_EN.
module alu_cmd_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input logic             clock,
  input logic             reset,
  alu_cmd_stage_if.slave  io
);
  cmd_t             push_cmd;
  cmd_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             head_is_nop;
  logic             issue;
  logic             res_issue;

  slot_e            slot_q, slot_d;
  logic [W-1:0]     data_q, data_d;
  flags_t           flags_q, flags_d;
  logic [W-1:0]     last_result_q, last_result_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Pack the incoming command; the forward bit is only kept when forwarding is built in.
  always_comb begin
    push_cmd.op = op_e'(io.io_in_op);
    push_cmd.a  = io.io_in_a;
    push_cmd.b  = io.io_in_b;
`ifdef ALU_FWD_EN
    push_cmd.fwd = io.io_in_fwd;
`else
    push_cmd.fwd = 1'b0;
`endif
  end

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (io.io_in_valid),
    .push_dat (push_cmd),
    .pop      (issue),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign io.io_in_ready = !fifo_full;

  // NOPs never occupy the slot, so they may always pop; real ops need a free or draining slot.
  assign head_is_nop = (head.op == OP_NOP);
  assign issue       = !fifo_empty && (head_is_nop || (slot_q == SLOT_EMPTY) || io.io_out_ready);
  assign res_issue   = issue && !head_is_nop;

  // Drive the ALU from the FIFO head (zeros when empty); fwd is never set without ALU_FWD_EN.
  always_comb begin
    io.io_alu_A       = '0;
    io.io_alu_B       = '0;
    io.io_alu_op_type = 3'h0;
    if (!fifo_empty) begin
      io.io_alu_A       = head.fwd ? last_result_q : head.a;
      io.io_alu_B       = head.b;
      io.io_alu_op_type = head.op;
    end
  end

  // Result slot, sticky overflow and issue counter next-state.
  always_comb begin
    slot_d        = slot_q;
    data_d        = data_q;
    flags_d       = flags_q;
    last_result_d = last_result_q;
    sticky_d      = io.io_clr_sticky ? 1'b0 : sticky_q;
    cnt_d         = issue ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
    if (res_issue) begin
      slot_d        = SLOT_FULL;
      data_d        = io.io_alu_out;
      flags_d       = '{ovf: io.io_alu_overflow, carry: io.io_alu_carry, zero: io.io_alu_zero};
      last_result_d = io.io_alu_out;
      if (io.io_alu_overflow) sticky_d = 1'b1;
    end else if ((slot_q == SLOT_FULL) && io.io_out_ready) begin
      slot_d = SLOT_EMPTY;
    end
  end

  // Slot and status registers; reset discards any held result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_q        <= SLOT_EMPTY;
      data_q        <= '0;
      flags_q       <= '0;
      last_result_q <= '0;
      sticky_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      slot_q        <= slot_d;
      data_q        <= data_d;
      flags_q       <= flags_d;
      last_result_q <= last_result_d;
      sticky_q      <= sticky_d;
      cnt_q         <= cnt_d;
    end
  end

  assign io.io_out_valid  = (slot_q == SLOT_FULL);
  assign io.io_out_data   = data_q;
  assign io.io_out_flags  = flags_q;
  assign io.io_sticky_ovf = sticky_q;
  assign io.io_issued_cnt = cnt_q;
endmodule

// File: tb/tb_alu_cmd_stage.sv
// Directed bench for alu_cmd_stage with a behavioural 4-bit ALU on the ALU port.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises full FIFO, held slot, NOP bypass and async reset.
module tb_alu_cmd_stage;
  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  alu_cmd_stage_if #(.W(4), .CNT_W(8)) io ();

  alu_cmd_stage #(.DEPTH(4), .W(4), .CNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .io    (io)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference 4-bit ALU: flags are signed overflow, carry/borrow and zero.
  always_comb begin
    logic [4:0] s;
    logic [3:0] a;
    logic [3:0] b;
    a = io.io_alu_A;
    b = io.io_alu_B;
    s = 5'd0;
    io.io_alu_carry    = 1'b0;
    io.io_alu_overflow = 1'b0;
    case (io.io_alu_op_type)
      3'h0: begin
        s = {1'b0, a} + {1'b0, b};
        io.io_alu_carry    = s[4];
        io.io_alu_overflow = (a[3] == b[3]) && (s[3] != a[3]);
      end
      3'h1: begin
        s = {1'b0, a} - {1'b0, b};
        io.io_alu_carry    = (a < b);
        io.io_alu_overflow = (a[3] != b[3]) && (s[3] != a[3]);
      end
      3'h2: s = {1'b0, ~a};
      3'h3: s = {1'b0, a & b};
      3'h4: s = {1'b0, a | b};
      3'h5: s = {1'b0, a ^ b};
      3'h6: s = {4'd0, ($signed(a) < $signed(b))};
      default: s = 5'd0;
    endcase
    io.io_alu_out  = s[3:0];
    io.io_alu_zero = (s[3:0] == 4'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a command and hold it until an edge accepts it (bounded wait).
  task automatic push(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic fwd);
    int n;
    n = 0;
    io.io_in_valid = 1'b1;
    io.io_in_op    = op;
    io.io_in_a     = a;
    io.io_in_b     = b;
    io.io_in_fwd   = fwd;
    while (!io.io_in_ready && n < 50) begin
      step();
      n++;
    end
    check("push_ready", io.io_in_ready, 1);
    step();
    io.io_in_valid = 1'b0;
    io.io_in_fwd   = 1'b0;
  endtask

  logic [3:0] exp_q2 [6];

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    io.io_in_valid   = 1'b0;
    io.io_in_op      = 3'h0;
    io.io_in_a       = 4'h0;
    io.io_in_b       = 4'h0;
    io.io_in_fwd     = 1'b0;
    io.io_out_ready  = 1'b1;
    io.io_clr_sticky = 1'b0;
    exp_q2[0] = 4'h2; exp_q2[1] = 4'h3; exp_q2[2] = 4'hA;
    exp_q2[3] = 4'h8; exp_q2[4] = 4'h5; exp_q2[5] = 4'h1;
    repeat (3) @(posedge clock);
    #1;

    // Reset state
    check("rst_in_ready", io.io_in_ready, 1);
    check("rst_out_valid", io.io_out_valid, 0);
    check("rst_out_data", io.io_out_data, 0);
    check("rst_out_flags", io.io_out_flags, 0);
    check("rst_sticky", io.io_sticky_ovf, 0);
    check("rst_cnt", io.io_issued_cnt, 0);
    check("rst_alu_op", io.io_alu_op_type, 0);
    reset = 1'b0;
    step();

    // 1: single add, result two edges after push
    push(3'h0, 4'd3, 4'd4, 1'b0);
    check("t1_valid_early", io.io_out_valid, 0);
    check("t1_alu_A", io.io_alu_A, 3);
    step();
    check("t1_valid", io.io_out_valid, 1);
    check("t1_data", io.io_out_data, 7);
    check("t1_flags", io.io_out_flags, 3'b000);
    check("t1_cnt", io.io_issued_cnt, 1);
    step();
    check("t1_drained", io.io_out_valid, 0);

    // 2: stalled consumer; slot holds one, FIFO fills with four
    io.io_out_ready = 1'b0;
    push(3'h0, 4'd1, 4'd1, 1'b0);
    push(3'h1, 4'd5, 4'd2, 1'b0);
    push(3'h5, 4'hF, 4'h5, 1'b0);
    push(3'h3, 4'hC, 4'hA, 1'b0);
    push(3'h4, 4'h1, 4'h4, 1'b0);
    check("t2_full", io.io_in_ready, 0);
    check("t2_cnt_stalled", io.io_issued_cnt, 2);
    check("t2_held", io.io_out_data, 2);
    fork
      push(3'h6, 4'd2, 4'd3, 1'b0);
      begin
        io.io_out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
          int n;
          n = 0;
          while (!io.io_out_valid && n < 20) begin
            step();
            n++;
          end
          check($sformatf("t2_valid%0d", k), io.io_out_valid, 1);
          check($sformatf("t2_data%0d", k), io.io_out_data, exp_q2[k]);
          step();
        end
      end
    join
    check("t2_cnt", io.io_issued_cnt, 7);
    check("t2_empty", io.io_out_valid, 0);

    // 3: overflow sets sticky; clear alone clears; clear with new overflow keeps it set
    push(3'h0, 4'd7, 4'd1, 1'b0);
    step();
    check("t3_data", io.io_out_data, 8);
    check("t3_flags", io.io_out_flags, 3'b100);
    check("t3_sticky", io.io_sticky_ovf, 1);
    io.io_clr_sticky = 1'b1;
    step();
    io.io_clr_sticky = 1'b0;
    check("t3_clr", io.io_sticky_ovf, 0);
    push(3'h0, 4'd4, 4'd4, 1'b0);
    io.io_clr_sticky = 1'b1;
    step();
    io.io_clr_sticky = 1'b0;
    check("t3_set_wins", io.io_sticky_ovf, 1);
    check("t3_flags2", io.io_out_flags, 3'b100);
    check("t3_cnt", io.io_issued_cnt, 9);
    step();

    // 4: NOP bypasses a full, stalled slot
    io.io_out_ready = 1'b0;
    push(3'h0, 4'd2, 4'd2, 1'b0);
    step();
    check("t4_data", io.io_out_data, 4);
    check("t4_cnt", io.io_issued_cnt, 10);
    push(3'h7, 4'd9, 4'd9, 1'b0);
    step();
    check("t4_nop_cnt", io.io_issued_cnt, 11);
    check("t4_nop_data", io.io_out_data, 4);
    check("t4_nop_valid", io.io_out_valid, 1);
    check("t4_nop_popped", io.io_alu_op_type, 0);
    io.io_out_ready = 1'b1;
    step();
    check("t4_drained", io.io_out_valid, 0);

    // 5: forwarding of last result into A
    push(3'h0, 4'd2, 4'd3, 1'b0);
    push(3'h0, 4'd9, 4'd1, 1'b1);
    check("t5_first", io.io_out_data, 5);
    step();
`ifdef ALU_FWD_EN
    check("t5_second", io.io_out_data, 6);
`else
    check("t5_second", io.io_out_data, 10);
`endif
    check("t5_cnt", io.io_issued_cnt, 13);
    step();

    // 6: async reset with a full slot and three queued commands
    io.io_out_ready = 1'b0;
    push(3'h0, 4'd7, 4'd7, 1'b0);
    push(3'h0, 4'd1, 4'd1, 1'b0);
    push(3'h0, 4'd1, 4'd2, 1'b0);
    push(3'h0, 4'd1, 4'd3, 1'b0);
    check("t6_pre_valid", io.io_out_valid, 1);
    check("t6_pre_sticky", io.io_sticky_ovf, 1);
    check("t6_pre_cnt", io.io_issued_cnt, 14);
    #2;
    reset = 1'b1;
    #1;
    check("t6_in_ready", io.io_in_ready, 1);
    check("t6_valid", io.io_out_valid, 0);
    check("t6_data", io.io_out_data, 0);
    check("t6_flags", io.io_out_flags, 0);
    check("t6_sticky", io.io_sticky_ovf, 0);
    check("t6_cnt", io.io_issued_cnt, 0);
    check("t6_alu_op", io.io_alu_op_type, 0);
    check("t6_alu_A", io.io_alu_A, 0);
    step();
    reset = 1'b0;
    io.io_out_ready = 1'b1;
    repeat (3) step();
    check("t6_discarded", io.io_out_valid, 0);
    check("t6_cnt_after", io.io_issued_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
